// File: rtl/notas_pkg.sv
// Shared note codes, reader FSM state type and song ROM field layout
// used by the note reader and its consumers.
package notas_pkg;

   localparam logic [7:0] NOTA_DO       = 8'd128;
   localparam logic [7:0] NOTA_RE       = 8'd64;
   localparam logic [7:0] NOTA_MI       = 8'd32;
   localparam logic [7:0] NOTA_FA       = 8'd16;
   localparam logic [7:0] NOTA_SOL      = 8'd8;
   localparam logic [7:0] NOTA_LA       = 8'd4;
   localparam logic [7:0] NOTA_SI       = 8'd2;
   localparam logic [7:0] NOTA_DO_ALTO  = 8'd1;
   localparam logic [7:0] NOTA_SILENCIO = 8'd0;

   localparam int unsigned NOTE_MSB = 11;
   localparam int unsigned NOTE_LSB = 4;
   localparam int unsigned DUR_MSB  = 3;
   localparam int unsigned DUR_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_PLAY,
      ST_GAP
   } state_t;

   // A note field is playable when it has at most one bit set (0 is a rest).
   function automatic logic note_is_valid(input logic [7:0] note);
      return (note & (note - 8'd1)) == 8'd0;
   endfunction

endpackage

// File: rtl/song_note_reader_if.sv
// Note reader bus: start/stop control, song ROM port and the note stream
// seen by the video decoder and tone generator.
interface song_note_reader_if #(
   parameter int unsigned ADDR_W = 5
);
   logic              start;
   logic              stop;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_data;
   logic [7:0]        nota_cancion;
   logic              leyendo;
   logic              note_strobe;
   logic              done;

   modport master (
      input  start, stop, rom_data,
      output rom_addr, nota_cancion, leyendo, note_strobe, done
   );

   modport slave (
      output start, stop, rom_data,
      input  rom_addr, nota_cancion, leyendo, note_strobe, done
   );
endinterface

// File: rtl/duration_timer.sv
// Unit counter plus tick counter: after load, expired is high in the last of
// units x (reload+1) cycles; used for both note and gap timing.
module duration_timer #(
   parameter int unsigned TICK_W = 24
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [3:0]        units,
   input  logic [TICK_W-1:0] reload,
   output logic              expired
);
   logic [3:0]        unit_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] tick_rl;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         unit_cnt <= '0;
         tick_cnt <= '0;
         tick_rl  <= '0;
      end else if (load) begin
         unit_cnt <= units;
         tick_cnt <= reload;
         tick_rl  <= reload;
      end else if (unit_cnt != 4'd0) begin
         if (tick_cnt == '0) begin
            unit_cnt <= unit_cnt - 4'd1;
            tick_cnt <= tick_rl;
         end else begin
            tick_cnt <= tick_cnt - TICK_W'(1);
         end
      end
   end

   assign expired = (unit_cnt == 4'd1) && (tick_cnt == '0);

endmodule

// File: rtl/song_note_reader.sv
// Song ROM player: fetches note entries and presents each as a timed one-hot
// note code. Optional macro SONG_LOOP_EN restarts the song instead of idling.
module song_note_reader
   import notas_pkg::*;
#(
   parameter int unsigned SONG_LEN   = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned NOTE_TICKS = 12_500_000,
   parameter int unsigned GAP_TICKS  = 1_250_000
) (
   input logic                clock,
   input logic                reset,
   song_note_reader_if.master bus
);
   localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int unsigned TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [TICK_W-1:0] NOTE_RL   = TICK_W'(NOTE_TICKS - 1);
   localparam logic [TICK_W-1:0] GAP_RL    = TICK_W'(GAP_TICKS - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
`ifdef SONG_LOOP_EN
   localparam state_t END_STATE = ST_FETCH;
`else
   localparam state_t END_STATE = ST_IDLE;
`endif

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr, addr_next;
   logic [7:0]        note_out, note_next;
   logic              reading, reading_next;
   logic              strobe, strobe_next;
   logic              finished, finished_next;

   logic [7:0]        entry_note;
   logic [3:0]        entry_dur;
   logic              last_entry;
   logic              song_end;
   logic              tmr_load;
   logic [3:0]        tmr_units;
   logic [TICK_W-1:0] tmr_reload;
   logic              tmr_expired;

   assign entry_note = bus.rom_data[NOTE_MSB:NOTE_LSB];
   assign entry_dur  = bus.rom_data[DUR_MSB:DUR_LSB];
   assign last_entry = (addr == LAST_ADDR);
   assign song_end   = ((state == ST_LOAD) && (entry_dur == 4'd0)) ||
                       ((state == ST_GAP) && tmr_expired && last_entry);

   duration_timer #(
      .TICK_W (TICK_W)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (bus.stop),
      .load    (tmr_load),
      .units   (tmr_units),
      .reload  (tmr_reload),
      .expired (tmr_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         addr     <= '0;
         note_out <= NOTA_SILENCIO;
         reading  <= 1'b0;
         strobe   <= 1'b0;
         finished <= 1'b0;
      end else begin
         state    <= state_next;
         addr     <= addr_next;
         note_out <= note_next;
         reading  <= reading_next;
         strobe   <= strobe_next;
         finished <= finished_next;
      end
   end

   always_comb begin
      state_next = state;
      if (bus.stop) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (bus.start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = (entry_dur == 4'd0) ? END_STATE : ST_PLAY;
            ST_PLAY:  if (tmr_expired) state_next = ST_GAP;
            ST_GAP:   if (tmr_expired) state_next = last_entry ? END_STATE : ST_FETCH;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Registered outputs are computed one cycle ahead; the timer is loaded on
   // the same edges that enter PLAY and GAP.
   always_comb begin
      addr_next     = addr;
      note_next     = note_out;
      reading_next  = reading;
      strobe_next   = 1'b0;
      finished_next = 1'b0;
      tmr_load      = 1'b0;
      tmr_units     = 4'd1;
      tmr_reload    = GAP_RL;
      if (bus.stop) begin
         addr_next    = '0;
         note_next    = NOTA_SILENCIO;
         reading_next = 1'b0;
      end else if (song_end) begin
         finished_next = 1'b1;
         addr_next     = '0;
`ifndef SONG_LOOP_EN
         reading_next  = 1'b0;
`endif
      end else begin
         case (state)
            ST_LOAD: begin
               note_next    = note_is_valid(entry_note) ? entry_note : NOTA_SILENCIO;
               strobe_next  = 1'b1;
               reading_next = 1'b1;
               tmr_load     = 1'b1;
               tmr_units    = entry_dur;
               tmr_reload   = NOTE_RL;
            end
            ST_PLAY: begin
               if (tmr_expired) begin
                  note_next = NOTA_SILENCIO;
                  tmr_load  = 1'b1;
               end
            end
            ST_GAP: begin
               if (tmr_expired) addr_next = addr + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.rom_addr     = addr;
   assign bus.nota_cancion = note_out;
   assign bus.leyendo      = reading;
   assign bus.note_strobe  = strobe;
   assign bus.done         = finished;

endmodule

// File: tb/tb_song_note_reader.sv
// Directed plus randomized check of song_note_reader against a per-cycle
// trace derived from the ROM contents; honours SONG_LOOP_EN.
module tb_song_note_reader;
   localparam int unsigned LEN = 4;
   localparam int unsigned AW  = 2;
   localparam int unsigned NT  = 4;
   localparam int unsigned GT  = 2;

   typedef struct packed {
      logic [7:0]    nota;
      logic          strobe;
      logic          leyendo;
      logic          done;
      logic [AW-1:0] addr;
   } samp_t;

   logic        clock;
   logic        reset;
   logic [11:0] rom [LEN];
   samp_t       model_q [$];
   int          compared   = 0;
   int          mismatched = 0;

   song_note_reader_if #(.ADDR_W(AW)) bus ();

   song_note_reader #(
      .SONG_LEN   (LEN),
      .ADDR_W     (AW),
      .NOTE_TICKS (NT),
      .GAP_TICKS  (GT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_ff @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " nota"},    bus.nota_cancion, 8'd0);
      check({tag, " strobe"},  {7'd0, bus.note_strobe}, 8'd0);
      check({tag, " leyendo"}, {7'd0, bus.leyendo}, 8'd0);
      check({tag, " done"},    {7'd0, bus.done}, 8'd0);
      check({tag, " addr"},    {6'd0, bus.rom_addr}, 8'd0);
   endtask

   task automatic check_sample(input string tag, input int idx);
      samp_t s;
      string t;
      s = model_q[idx];
      t = $sformatf("%s[%0d]", tag, idx);
      check({t, " nota"},    bus.nota_cancion, s.nota);
      check({t, " strobe"},  {7'd0, bus.note_strobe}, {7'd0, s.strobe});
      check({t, " leyendo"}, {7'd0, bus.leyendo}, {7'd0, s.leyendo});
      check({t, " done"},    {7'd0, bus.done}, {7'd0, s.done});
      check({t, " addr"},    {6'd0, bus.rom_addr}, {6'd0, s.addr});
   endtask

   task automatic push(input logic [7:0] n, input logic s, input logic l, input logic d, input int a);
      samp_t x;
      x.nota = n; x.strobe = s; x.leyendo = l; x.done = d; x.addr = AW'(a);
      model_q.push_back(x);
   endtask

   // One sample per clock after the edge that accepts start.
   task automatic build_model();
      int  passes;
      bit  first;
      bit  pend;
      bit  ended;
      logic [7:0] n;
      int  d;
      model_q.delete();
`ifdef SONG_LOOP_EN
      passes = 2;
`else
      passes = 1;
`endif
      first = 1; pend = 0; ended = 0;
      for (int p = 0; p < passes && !ended; p++) begin
         for (int i = 0; i < int'(LEN) && !ended; i++) begin
            n = rom[i][11:4];
            d = int'(rom[i][3:0]);
            push(8'd0, 1'b0, !first, pend, i);
            pend = 0;
            push(8'd0, 1'b0, !first, 1'b0, i);
            if (d != 0) begin
               for (int c = 0; c < d * int'(NT); c++)
                  push(($countones(n) <= 1) ? n : 8'd0, c == 0, 1'b1, 1'b0, i);
               first = 0;
               for (int c = 0; c < int'(GT); c++) push(8'd0, 1'b0, 1'b1, 1'b0, i);
            end
            if (d == 0 || i == int'(LEN) - 1) begin
`ifdef SONG_LOOP_EN
               pend = 1;
               break;
`else
               push(8'd0, 1'b0, 1'b0, 1'b1, 0);
               ended = 1;
`endif
            end
         end
      end
   endtask

   task automatic start_and_check(input string tag, input int n);
      @(negedge clock); bus.start = 1'b1;
      @(negedge clock); bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check_sample(tag, i);
         if (i < n - 1) @(negedge clock);
      end
   endtask

   task automatic run_full(input string tag);
      build_model();
      start_and_check(tag, model_q.size());
`ifdef SONG_LOOP_EN
      bus.stop = 1'b1;
`endif
      @(negedge clock); bus.stop = 1'b0;
      check_idle({tag, " after"});
   endtask

   task automatic plan_rom();
      rom[0] = {8'd128, 4'd1};
      rom[1] = {8'd32,  4'd2};
      rom[2] = {8'd8,   4'd1};
      rom[3] = {8'd1,   4'd1};
   endtask

   initial begin
      int k;
      int r;
      reset = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
      plan_rom();
      repeat (3) @(negedge clock);
      check_idle("reset");
      reset = 1'b0;

      run_full("single");

      rom[2][3:0] = 4'd0;
      run_full("marker");

      // stop during the third cycle of note 32
      plan_rom();
      build_model();
      k = 0;
      for (int i = 0; i < model_q.size(); i++)
         if (model_q[i].nota == 8'd32) begin k = i + 2; break; end
      start_and_check("stop", k + 1);
      bus.stop = 1'b1;
      @(negedge clock); bus.stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_idle("stopped");
         @(negedge clock);
      end

      rom[1] = {8'h03, 4'd1};
      run_full("invalid");

      @(negedge clock); bus.start = 1'b1; bus.stop = 1'b1;
      @(negedge clock); bus.start = 1'b0; bus.stop = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_idle("start_stop");
         @(negedge clock);
      end

      // reset during the first gap, then replay from address 0
      plan_rom();
      build_model();
      k = 0;
      for (int i = 1; i < model_q.size(); i++)
         if (model_q[i-1].nota != 8'd0 && model_q[i].nota == 8'd0) begin k = i; break; end
      start_and_check("gap", k + 1);
      reset = 1'b1;
      @(negedge clock);
      check_idle("reset_gap");
      reset = 1'b0;
      run_full("replay");

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < int'(LEN); i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       rom[i][11:4] = 8'd1 << r;
            else if (r == 8) rom[i][11:4] = 8'd0;
            else             rom[i][11:4] = 8'($urandom);
            rom[i][3:0] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
         end
         run_full($sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/song_note_reader.md
# song_note_reader

Plays a stored song by reading note entries from a song ROM and presenting them, one at a time and for a timed duration, as one-hot note codes with a "reading" qualifier. It is the producing end of the note interface consumed by the video note-position decoder and the tone generator. It sits between the song ROM and those consumers, under control of the game's start/stop logic.

## Interface
- `SONG_LEN`, default 32: number of ROM entries in the song; must be ≥ 2.
- `ADDR_W`, default 5: ROM address width; 2^ADDR_W ≥ SONG_LEN.
- `NOTE_TICKS`, default 12_500_000: clock cycles per duration unit (0.25 s at 50 MHz).
- `GAP_TICKS`, default 1_250_000: silent cycles between notes; must be ≥ 1.
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: level-sampled; begins playback from address 0 when idle.
- `stop`  in  1: aborts playback.
- `rom_addr`  out  ADDR_W: song ROM address.
- `rom_data`  in  12: `[11:4]` one-hot note (DO=128 … DO-high=1, 0=rest); `[3:0]` duration in units, where 0 is the end-of-song marker. Valid one cycle after `rom_addr`.
- `nota_cancion`  out  8: current note code.
- `leyendo`  out  1: high while a song is being played (PLAY and GAP states).
- `note_strobe`  out  1: one-cycle pulse when a new note is presented.
- `done`  out  1: one-cycle pulse when the song ends naturally.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE → FETCH when `start`=1 and `stop`=0. `rom_addr` is 0.
- FETCH: one wait cycle for ROM latency. Then go to LOAD.
- LOAD: latch `rom_data`.
  - If duration = 0 (end marker): the song ends.
  - Otherwise go to PLAY.
- PLAY: `nota_cancion` = latched note for duration × NOTE_TICKS cycles.
  - Use a unit counter (4-bit) plus a tick counter (⌈log2 NOTE_TICKS⌉ bits). No multiplier.
  - `note_strobe` pulses in the first PLAY cycle.
- GAP: `nota_cancion` = 0 for GAP_TICKS cycles. Then:
  - if `rom_addr` = SONG_LEN−1, the song ends;
  - otherwise `rom_addr`+1 → FETCH.
- Song end: `done` pulses for one cycle, `rom_addr` returns to 0, and the FSM goes to IDLE (see Configuration for the loop variant).
- Invalid note field (not one-hot and not 0): the entry is played as a rest (`nota_cancion` = 0) for its full duration. `note_strobe` still pulses.
- `stop`=1 in any state: the next state is IDLE, with `rom_addr`=0 and `nota_cancion`=0. `leyendo` falls on the next edge and `done` does not pulse.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` outside IDLE is ignored.
- Holding `start` high after the song ends restarts playback from IDLE on the next cycle.

## Timing
- Reset values: state=IDLE, `rom_addr`=0, `nota_cancion`=0, `leyendo`=0, `note_strobe`=0, `done`=0, all counters 0.
- All outputs are registered.
- Latency from `start` (sampled at edge E) to the first note: FETCH after E, LOAD after E+1, and `nota_cancion`/`note_strobe`/`leyendo` valid after E+2.
- Per-entry period: 2 (FETCH+LOAD) + dur×NOTE_TICKS + GAP_TICKS cycles.
- During FETCH/LOAD between notes: `nota_cancion`=0 and `leyendo` stays 1.
- `done` is asserted in the cycle the FSM enters IDLE from a natural end.
- Reset mid-song overrides `stop`/`start` and yields exactly the reset values on the next cycle.

## Configuration
- `SONG_LOOP_EN` defined: on song end (last address or end marker), skip IDLE.
  - `rom_addr` → 0 and go to FETCH. `done` still pulses once per pass.
  - `leyendo` stays high until `stop` or `reset`.
- Undefined: the song plays once and the FSM returns to IDLE as described above.

## Structure
- Shared package `notas_pkg`:
  - one-hot note constants (NOTA_DO=8'd128 … NOTA_DO_ALTO=8'd1, NOTA_SILENCIO=8'd0);
  - state encoding typedef;
  - ROM field positions (NOTE_MSB=11, NOTE_LSB=4, DUR_MSB=3, DUR_LSB=0).
- One sub-module: `duration_timer` (unit counter + tick counter, `load`/`expired` interface), reused for PLAY and GAP.
- The ROM is external to this block.

## Test plan
All scenarios use NOTE_TICKS=4, GAP_TICKS=2, SONG_LEN=4; ROM = {128/1, 32/2, 8/1, 1/1}.
- Single pass:
  - Stimulus: pulse `start`.
  - Required response: `nota_cancion` = 128 for 4 cycles, 0 for 2, then 32 for 8, 8 for 4, 1 for 4. `note_strobe` pulses 4 times, `done` pulses once, and `leyendo` ends low.
- End marker:
  - Stimulus: set ROM[2] duration to 0.
  - Required response: only 128 and 32 play, `done` pulses after the GAP following 32, and `rom_addr` returns to 0.
- Stop mid-note:
  - Stimulus: assert `stop` in the 3rd cycle of 32.
  - Required response: next cycle `nota_cancion`=0, `leyendo`=0, `rom_addr`=0, and no `done`.
- Invalid and simultaneous inputs:
  - Stimulus: entry note=8'h03 with dur 1, followed by `start`+`stop` asserted together in IDLE.
  - Required response: the invalid entry gives 0 for 4 cycles with a strobe; the simultaneous `start`+`stop` leaves the FSM in IDLE.
- Reset mid-GAP:
  - Stimulus: assert `reset` during a GAP.
  - Required response: all outputs at reset values the next cycle; a later `start` replays from address 0.
- Loop:
  - Stimulus: build with `SONG_LOOP_EN`.
  - Required response: after note 1, the sequence restarts at 128 without `leyendo` dropping, and `done` pulses once per pass.
